// File: rtl/eject_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eject_arbiter
// Description : Four-input packet-level round-robin ejection arbiter with a
//               one-deep registered output stage toward the local sink.
// Revision    : 1.0 - initial release
// ============================================================================

module eject_arbiter #(
   parameter int flitWidth = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 match1,
   input  logic                 match2,
   input  logic                 match3,
   input  logic                 match4,
   input  logic                 valid1,
   input  logic                 valid2,
   input  logic                 valid3,
   input  logic                 valid4,
   input  logic [flitWidth-1:0] data1,
   input  logic [flitWidth-1:0] data2,
   input  logic [flitWidth-1:0] data3,
   input  logic [flitWidth-1:0] data4,
   input  logic                 tail1,
   input  logic                 tail2,
   input  logic                 tail3,
   input  logic                 tail4,
   output logic                 ack1,
   output logic                 ack2,
   output logic                 ack3,
   output logic                 ack4,
   output logic                 out_valid,
   output logic [flitWidth-1:0] out_data,
   output logic                 out_tail,
   input  logic                 out_ready
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   logic [3:0]           valid_v;
   logic [3:0]           match_v;
   logic [3:0]           tail_v;
   logic [3:0]           req_v;
   logic [flitWidth-1:0] data_v [4];

   assign valid_v   = {valid4, valid3, valid2, valid1};
   assign match_v   = {match4, match3, match2, match1};
   assign tail_v    = {tail4, tail3, tail2, tail1};
   assign data_v[0] = data1;
   assign data_v[1] = data2;
   assign data_v[2] = data3;
   assign data_v[3] = data4;
   assign req_v     = valid_v & match_v;

   state_t               state_q, state_d;
   logic [1:0]           rr_ptr_q, rr_ptr_d;
   logic [1:0]           owner_q, owner_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_tail_q, out_tail_d;
   logic [flitWidth-1:0] out_data_q, out_data_d;

   logic                 accept;
   logic                 consume;
   logic [1:0]           sel;
   logic                 rr_found;
   logic [1:0]           rr_sel;
   logic [3:0]           ack_v;

   // The output register can take a new flit when empty or draining this cycle.
   assign accept = !out_valid_q || out_ready;

   always_comb begin
      rr_found = 1'b0;
      rr_sel   = rr_ptr_q;
      for (int k = 0; k < 4; k++) begin
         if (!rr_found && req_v[rr_ptr_q + 2'(k)]) begin
            rr_found = 1'b1;
            rr_sel   = rr_ptr_q + 2'(k);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_tail_d  = out_tail_q;
      consume     = 1'b0;
      sel         = owner_q;

      case (state_q)
         ST_IDLE: begin
            if (accept && rr_found) begin
               consume = 1'b1;
               sel     = rr_sel;
            end
         end
         ST_LOCKED: begin
            // Body and tail flits follow the header, so match is not required.
            if (accept && valid_v[owner_q]) begin
               consume = 1'b1;
               sel     = owner_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (consume) begin
         out_valid_d = 1'b1;
         out_data_d  = data_v[sel];
         out_tail_d  = tail_v[sel];
         if (tail_v[sel]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = sel + 2'd1;
         end else begin
            state_d  = ST_LOCKED;
            owner_d  = sel;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Reset gates the acks so upstream never pops while the arbiter is held.
   assign ack_v = (consume && rst_n) ? (4'b0001 << sel) : 4'b0000;

   assign ack1      = ack_v[0];
   assign ack2      = ack_v[1];
   assign ack3      = ack_v[2];
   assign ack4      = ack_v[3];
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_tail  = out_tail_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= 2'd0;
         owner_q     <= 2'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_tail_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_tail_q  <= out_tail_d;
      end
   end

`ifndef SYNTHESIS
   a_ack_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(ack_v));

   a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid_q && !out_ready) |=> ($stable(out_data_q) && $stable(out_tail_q) && out_valid_q));

   a_ack_needs_valid : assert property (@(posedge clk) disable iff (!rst_n)
      ((ack_v & ~valid_v) == 4'b0000));
`endif

endmodule

`default_nettype wire

// File: tb/tb_eject_arbiter.sv
`default_nettype none
// Directed self-checking bench for eject_arbiter: single flit, contention,
// packet lock with bubble, backpressure, non-match and mid-packet reset.

module tb_eject_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] v;
   logic [3:0] m;
   logic [3:0] t;
   logic [7:0] d1, d2, d3, d4;
   logic       out_ready;
   logic       a1, a2, a3, a4;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_tail;
   logic [3:0] ack;

   int n_cmp;
   int n_err;

   assign ack = {a4, a3, a2, a1};

   eject_arbiter #(.flitWidth(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .match1    (m[0]),
      .match2    (m[1]),
      .match3    (m[2]),
      .match4    (m[3]),
      .valid1    (v[0]),
      .valid2    (v[1]),
      .valid3    (v[2]),
      .valid4    (v[3]),
      .data1     (d1),
      .data2     (d2),
      .data3     (d3),
      .data4     (d4),
      .tail1     (t[0]),
      .tail2     (t[1]),
      .tail3     (t[2]),
      .tail4     (t[3]),
      .ack1      (a1),
      .ack2      (a2),
      .ack3      (a3),
      .ack4      (a4),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_tail  (out_tail),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      v = 4'b0; m = 4'b0; t = 4'b0;
      d1 = 8'h00; d2 = 8'h00; d3 = 8'h00; d4 = 8'h00;
      out_ready = 1'b0;
   endtask

   task automatic apply_reset;
      tick;
      rst_n = 1'b0;
      clear_inputs;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      tick;
      rst_n = 1'b0;
      v = 4'b0001; m = 4'b0001; t = 4'b0001; d1 = 8'hEE; out_ready = 1'b1;
      #1;
      n_cmp++;
      if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want %b", ack, 4'b0000); end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_cmp++;
      if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", out_data); end
      n_cmp++;
      if (out_tail !== 1'b0) begin n_err++; $display("FAIL reset_tail: got %b want 0", out_tail); end
      tick;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_hold_valid: got %b want 0", out_valid); end
      clear_inputs;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      apply_reset;
      v[1] = 1'b1; m[1] = 1'b1; t[1] = 1'b1; d2 = 8'hA5; out_ready = 1'b1;
      #1;
      n_cmp++;
      if (ack !== 4'b0010) begin n_err++; $display("FAIL single_ack: got %b want %b", ack, 4'b0010); end
      tick;
      v[1] = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
      n_cmp++;
      if (out_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", out_data); end
      n_cmp++;
      if (out_tail !== 1'b1) begin n_err++; $display("FAIL single_tail: got %b want 1", out_tail); end
      #1;
      n_cmp++;
      if (ack !== 4'b0000) begin n_err++; $display("FAIL single_noack: got %b want %b", ack, 4'b0000); end
      tick;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", out_valid); end
      // Still IDLE: a fresh single-flit packet on port 3 is granted at once.
      v[2] = 1'b1; m[2] = 1'b1; t[2] = 1'b1; d3 = 8'h3C;
      #1;
      n_cmp++;
      if (ack !== 4'b0100) begin n_err++; $display("FAIL single_idle_ack: got %b want %b", ack, 4'b0100); end
      tick;
      v[2] = 1'b0;
      n_cmp++;
      if (out_data !== 8'h3C) begin n_err++; $display("FAIL single_idle_data: got %h want 3c", out_data); end
   endtask

   task automatic test_contention;
      logic [3:0] exp_ack;
      logic [7:0] exp_data;
      apply_reset;
      v = 4'b1111; m = 4'b1111; t = 4'b1111;
      d1 = 8'h10; d2 = 8'h20; d3 = 8'h30; d4 = 8'h40; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_ack  = 4'b0001 << (i % 4);
         exp_data = 8'h10 * 8'((i % 4) + 1);
         #1;
         n_cmp++;
         if (ack !== exp_ack) begin n_err++; $display("FAIL contention_ack[%0d]: got %b want %b", i, ack, exp_ack); end
         tick;
         n_cmp++;
         if (out_data !== exp_data) begin n_err++; $display("FAIL contention_data[%0d]: got %h want %h", i, out_data, exp_data); end
      end
      clear_inputs;
   endtask

   task automatic test_lock;
      apply_reset;
      out_ready = 1'b1;
      v[2] = 1'b1; m[2] = 1'b1; t[2] = 1'b0; d3 = 8'h11;
      #1;
      n_cmp++;
      if (ack !== 4'b0100) begin n_err++; $display("FAIL lock_head_ack: got %b want %b", ack, 4'b0100); end
      tick;
      n_cmp++;
      if (out_data !== 8'h11) begin n_err++; $display("FAIL lock_head_data: got %h want 11", out_data); end
      d3 = 8'h22; m[2] = 1'b0;
      v[0] = 1'b1; m[0] = 1'b1; t[0] = 1'b1; d1 = 8'h77;
      #1;
      n_cmp++;
      if (ack !== 4'b0100) begin n_err++; $display("FAIL lock_body_ack: got %b want %b", ack, 4'b0100); end
      tick;
      n_cmp++;
      if (out_data !== 8'h22) begin n_err++; $display("FAIL lock_body_data: got %h want 22", out_data); end
      v[2] = 1'b0;
      #1;
      n_cmp++;
      if (ack !== 4'b0000) begin n_err++; $display("FAIL lock_bubble_ack: got %b want %b", ack, 4'b0000); end
      tick;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL lock_bubble_valid: got %b want 0", out_valid); end
      v[2] = 1'b1; d3 = 8'h33; t[2] = 1'b1;
      #1;
      n_cmp++;
      if (ack !== 4'b0100) begin n_err++; $display("FAIL lock_tail_ack: got %b want %b", ack, 4'b0100); end
      tick;
      n_cmp++;
      if (out_data !== 8'h33 || out_tail !== 1'b1) begin
         n_err++; $display("FAIL lock_tail_data: got %h/%b want 33/1", out_data, out_tail);
      end
      v[2] = 1'b0;
      #1;
      n_cmp++;
      if (ack !== 4'b0001) begin n_err++; $display("FAIL lock_next_ack: got %b want %b", ack, 4'b0001); end
      tick;
      n_cmp++;
      if (out_data !== 8'h77) begin n_err++; $display("FAIL lock_next_data: got %h want 77", out_data); end
      clear_inputs;
   endtask

   task automatic test_backpressure;
      apply_reset;
      out_ready = 1'b1;
      v[1] = 1'b1; m[1] = 1'b1; t[1] = 1'b1; d2 = 8'h5A;
      #1;
      n_cmp++;
      if (ack !== 4'b0010) begin n_err++; $display("FAIL bp_first_ack: got %b want %b", ack, 4'b0010); end
      tick;
      v[1] = 1'b0; out_ready = 1'b0;
      v[2] = 1'b1; m[2] = 1'b1; t[2] = 1'b1; d3 = 8'hC3;
      v[3] = 1'b1; m[3] = 1'b1; t[3] = 1'b1; d4 = 8'hD4;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if (ack !== 4'b0000) begin n_err++; $display("FAIL bp_stall_ack[%0d]: got %b want %b", i, ack, 4'b0000); end
         tick;
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            n_err++; $display("FAIL bp_stall_hold[%0d]: got %b/%h want 1/5a", i, out_valid, out_data);
         end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (ack !== 4'b0100) begin n_err++; $display("FAIL bp_release_ack: got %b want %b", ack, 4'b0100); end
      tick;
      v[2] = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'hC3) begin
         n_err++; $display("FAIL bp_replace: got %b/%h want 1/c3", out_valid, out_data);
      end
      clear_inputs;
   endtask

   task automatic test_nonmatch;
      apply_reset;
      out_ready = 1'b1;
      v[3] = 1'b1; m[3] = 1'b0; t[3] = 1'b1; d4 = 8'h44;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (ack !== 4'b0000) begin n_err++; $display("FAIL nomatch_ack[%0d]: got %b want %b", i, ack, 4'b0000); end
         tick;
         n_cmp++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL nomatch_valid[%0d]: got %b want 0", i, out_valid); end
      end
      clear_inputs;
   endtask

   task automatic test_reset_mid;
      apply_reset;
      out_ready = 1'b1;
      v[1] = 1'b1; m[1] = 1'b1; t[1] = 1'b0; d2 = 8'h21;
      #1;
      n_cmp++;
      if (ack !== 4'b0010) begin n_err++; $display("FAIL rmid_head_ack: got %b want %b", ack, 4'b0010); end
      tick;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h21) begin
         n_err++; $display("FAIL rmid_head_out: got %b/%h want 1/21", out_valid, out_data);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
         n_err++; $display("FAIL rmid_async_clear: got %b/%h want 0/00", out_valid, out_data);
      end
      d2 = 8'h2B;
      v[0] = 1'b1; m[0] = 1'b1; t[0] = 1'b1; d1 = 8'h99;
      #1;
      n_cmp++;
      if (ack !== 4'b0000) begin n_err++; $display("FAIL rmid_reset_ack: got %b want %b", ack, 4'b0000); end
      tick;
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (ack !== 4'b0001) begin n_err++; $display("FAIL rmid_restart_ack: got %b want %b", ack, 4'b0001); end
      tick;
      v[0] = 1'b0;
      n_cmp++;
      if (out_data !== 8'h99) begin n_err++; $display("FAIL rmid_restart_data: got %h want 99", out_data); end
      clear_inputs;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      clear_inputs;
      #12;
      rst_n = 1'b1;
      test_reset;
      test_single;
      test_contention;
      test_lock;
      test_backpressure;
      test_nonmatch;
      test_reset_mid;
      tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
